// File: rtl/shift_unit_arbiter.sv
// ---------------------------------------------------------------------------
// shift_unit_arbiter
//
// Shares one 32-bit shift datapath (logical left / arithmetic right) between
// two requesters. A round-robin arbiter accepts one request at a time and
// latches its operands. The shifter result is registered one cycle later. It
// is then held on a valid/ready response channel until the consumer takes it.
// A wrapping counter records how many responses have been handshaked.
//
// Ports:
//   clock        system clock, all state updates on the rising edge
//   reset        synchronous, active-high reset
//   req_valid    per-requester request valid (bit i = requester i)
//   req_ready    per-requester accept, one-hot or zero, only in IDLE
//   req_op0/1    requester op: 0 = sll, 1 = sra
//   req_a0/1     requester 32-bit operand
//   req_shamt0/1 requester 5-bit shift amount
//   resp_valid   result available (state RESP)
//   resp_ready   consumer accepts the result
//   resp_id      requester that owns resp_data
//   resp_data    shifted result
//   busy         high whenever the FSM is not IDLE
//   op_count     completed (handshaked) responses, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------

// Combinational logical left shifter, zero fill.
module shift_sll (
    input  logic [31:0] a,
    input  logic [4:0]  shamt,
    output logic [31:0] y
);
    assign y = a << shamt;
endmodule

// Combinational arithmetic right shifter, fills with a[31].
module shift_sra (
    input  logic [31:0] a,
    input  logic [4:0]  shamt,
    output logic [31:0] y
);
    assign y = $unsigned($signed(a) >>> shamt);
endmodule

module shift_unit_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic             req_op0,
    input  logic [31:0]      req_a0,
    input  logic [4:0]       req_shamt0,
    input  logic             req_op1,
    input  logic [31:0]      req_a1,
    input  logic [4:0]       req_shamt1,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [31:0]      resp_data,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    logic        last_grant;
    logic        op_q;
    logic [31:0] a_q;
    logic [4:0]  shamt_q;
    logic        id_q;
    logic [31:0] result_q;

    logic [1:0]  grant;
    logic        grant_id;
    logic        sel_op;
    logic [31:0] sel_a;
    logic [4:0]  sel_shamt;
    logic [31:0] sll_out;
    logic [31:0] sra_out;

    // Round-robin choice: a lone requester always wins, on a tie the
    // requester that was not served last time wins.
    always_comb begin
        grant = 2'b00;
        case (req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Accept only in IDLE and never during the reset cycle, so a request
    // presented while the response handshakes waits for the IDLE cycle.
    assign req_ready = (state == IDLE && !reset) ? grant : 2'b00;
    assign grant_id  = grant[1];

    assign sel_op    = grant_id ? req_op1    : req_op0;
    assign sel_a     = grant_id ? req_a1     : req_a0;
    assign sel_shamt = grant_id ? req_shamt1 : req_shamt0;

    // The shifters only ever see the latched operands.
    shift_sll u_sll (
        .a     (a_q),
        .shamt (shamt_q),
        .y     (sll_out)
    );

    shift_sra u_sra (
        .a     (a_q),
        .shamt (shamt_q),
        .y     (sra_out)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            op_q       <= 1'b0;
            a_q        <= '0;
            shamt_q    <= '0;
            id_q       <= 1'b0;
            result_q   <= '0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_ready) begin
                        op_q       <= sel_op;
                        a_q        <= sel_a;
                        shamt_q    <= sel_shamt;
                        id_q       <= grant_id;
                        last_grant <= grant_id;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    result_q <= op_q ? sra_out : sll_out;
                    state    <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        op_count <= op_count + CNT_W'(1);
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);
    assign resp_id    = id_q;
    assign resp_data  = result_q;

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// ---------------------------------------------------------------------------
// tb_shift_unit_arbiter
//
// Self-checking bench for shift_unit_arbiter (CNT_W = 4 so the counter wrap
// is reachable quickly). A cycle model tracks the arbiter state, last grant
// and completed count. Each accepted request pushes its expected {id, data}
// onto a scoreboard queue. The entry is compared every RESP cycle and popped
// on the handshake. Directed sequences add checks against literal values.
// ---------------------------------------------------------------------------
module tb_shift_unit_arbiter;

    localparam int CNT_W = 4;

    logic             clock;
    logic             reset;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic             req_op0;
    logic [31:0]      req_a0;
    logic [4:0]       req_shamt0;
    logic             req_op1;
    logic [31:0]      req_a1;
    logic [4:0]       req_shamt1;
    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [31:0]      resp_data;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    shift_unit_arbiter #(.CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op0    (req_op0),
        .req_a0     (req_a0),
        .req_shamt0 (req_shamt0),
        .req_op1    (req_op1),
        .req_a1     (req_a1),
        .req_shamt1 (req_shamt1),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .busy       (busy),
        .op_count   (op_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        id;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   assert_count = 0;
    int   fail_count   = 0;
    int   cycle        = 0;

    // Model state: 0 = IDLE, 1 = EXEC, 2 = RESP
    int   m_state     = 0;
    logic m_last      = 1'b1;
    int   m_count     = 0;
    bit   model_valid = 0;
    bit   spacing_on  = 0;
    bit   have_prev   = 0;
    int   prev_accept = 0;
    int   grant_log[$];

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at cycle %0d",
                     tag, observed, expected, cycle);
        end
    endtask

    task automatic report_timeout(input string tag);
        assert_count++;
        fail_count++;
        $display("[TB] FAIL %s: timed out at cycle %0d", tag, cycle);
    endtask

    // Bit-by-bit reference shifter.
    function automatic logic [31:0] model_shift(input logic op, input logic [31:0] a,
                                                input logic [4:0] sh);
        logic [31:0] r;
        int src;
        for (int i = 0; i < 32; i++) begin
            if (op) begin
                src  = i + int'(sh);
                r[i] = (src > 31) ? a[31] : a[src];
            end else begin
                src  = i - int'(sh);
                r[i] = (src < 0) ? 1'b0 : a[src];
            end
        end
        return r;
    endfunction

    function automatic logic [1:0] model_grant(input logic [1:0] v, input logic last);
        case (v)
            2'b01:   return 2'b01;
            2'b10:   return 2'b10;
            2'b11:   return last ? 2'b01 : 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    always @(posedge clock) cycle <= cycle + 1;

    // Model and scoreboard, evaluated mid-cycle while inputs are stable.
    always @(negedge clock) begin
        logic [1:0] exp_ready;
        exp_t       e;
        exp_t       front;
        if (reset) begin
            check_value("ready_in_reset", {30'd0, req_ready}, 32'd0);
            m_state     = 0;
            m_last      = 1'b1;
            m_count     = 0;
            sb.delete();
            model_valid = 1;
            have_prev   = 0;
        end else if (model_valid) begin
            exp_ready = (m_state == 0) ? model_grant(req_valid, m_last) : 2'b00;
            check_value("req_ready", {30'd0, req_ready}, {30'd0, exp_ready});
            check_value("busy", {31'd0, busy}, {31'd0, (m_state != 0)});
            check_value("resp_valid", {31'd0, resp_valid}, {31'd0, (m_state == 2)});
            check_value("op_count", {28'd0, op_count}, 32'(m_count));
            case (m_state)
                0: begin
                    if (exp_ready != 2'b00) begin
                        e.id   = exp_ready[1];
                        e.data = e.id ? model_shift(req_op1, req_a1, req_shamt1)
                                      : model_shift(req_op0, req_a0, req_shamt0);
                        sb.push_back(e);
                        m_last  = e.id;
                        m_state = 1;
                        if (spacing_on) begin
                            grant_log.push_back(int'(e.id));
                            if (have_prev)
                                check_value("accept_spacing", 32'(cycle - prev_accept), 32'd3);
                        end
                        prev_accept = cycle;
                        have_prev   = 1;
                    end
                end
                1: m_state = 2;
                default: begin
                    if (sb.size() == 0) begin
                        report_timeout("scoreboard_empty");
                    end else begin
                        front = sb[0];
                        check_value("resp_id", {31'd0, resp_id}, {31'd0, front.id});
                        check_value("resp_data", resp_data, front.data);
                        if (resp_ready) begin
                            void'(sb.pop_front());
                            m_count = (m_count + 1) % (1 << CNT_W);
                            m_state = 0;
                        end
                    end
                end
            endcase
        end
    end

    // Present a request and hold it until accepted; returns just after the
    // accepting edge, i.e. during the EXEC cycle.
    task automatic applyStimulus(input logic id, input logic op, input logic [31:0] a,
                                 input logic [4:0] sh);
        bit accepted;
        accepted = 0;
        if (id) begin
            req_op1 = op; req_a1 = a; req_shamt1 = sh;
        end else begin
            req_op0 = op; req_a0 = a; req_shamt0 = sh;
        end
        req_valid = id ? 2'b10 : 2'b01;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clock);
            if (req_ready[id]) accepted = 1;
        end
        if (!accepted) report_timeout("accept_wait");
        @(posedge clock);
        #1;
        req_valid = 2'b00;
    endtask

    // Wait for the response, compare against a literal, let it handshake.
    task automatic checkOutput(input logic id, input logic [31:0] exp_data);
        bit seen;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (resp_valid) seen = 1;
        end
        if (!seen) begin
            report_timeout("resp_wait");
        end else begin
            check_value("direct_data", resp_data, exp_data);
            check_value("direct_id", {31'd0, resp_id}, {31'd0, id});
        end
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int guard;
        reset      = 1'b1;
        req_valid  = 2'b00;
        req_op0    = 1'b0; req_a0 = '0; req_shamt0 = '0;
        req_op1    = 1'b0; req_a1 = '0; req_shamt1 = '0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clock);
        check_value("rst_busy", {31'd0, busy}, 32'd0);
        check_value("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_value("rst_op_count", {28'd0, op_count}, 32'd0);
        check_value("rst_resp_data", resp_data, 32'd0);
        check_value("rst_resp_id", {31'd0, resp_id}, 32'd0);
        @(posedge clock);
        #1;

        // Basic sra and sll cases
        resp_ready = 1'b1;
        applyStimulus(1'b0, 1'b1, 32'h8000_0000, 5'd4);
        checkOutput(1'b0, 32'hF800_0000);
        @(negedge clock);
        check_value("op_count_first", {28'd0, op_count}, 32'd1);
        @(posedge clock);
        #1;
        applyStimulus(1'b1, 1'b0, 32'h0000_0001, 5'd31);
        checkOutput(1'b1, 32'h8000_0000);
        applyStimulus(1'b1, 1'b1, 32'h7FFF_FFFF, 5'd16);
        checkOutput(1'b1, 32'h0000_7FFF);
        applyStimulus(1'b1, 1'b1, 32'hDEAD_BEEF, 5'd0);
        checkOutput(1'b1, 32'hDEAD_BEEF);

        // Continuous tie from reset: alternating grants, 3-cycle spacing
        pulse_reset();
        req_op0 = 1'b0; req_a0 = 32'h1234_5678; req_shamt0 = 5'd3;
        req_op1 = 1'b1; req_a1 = 32'hF000_000F; req_shamt1 = 5'd7;
        grant_log.delete();
        spacing_on = 1;
        req_valid  = 2'b11;
        repeat (13) @(posedge clock);
        #1;
        req_valid  = 2'b00;
        spacing_on = 0;
        repeat (4) @(posedge clock);
        #1;
        check_value("tie_grant_count_ok", {31'd0, (grant_log.size() >= 4)}, 32'd1);
        if (grant_log.size() >= 4) begin
            for (int k = 0; k < 4; k++)
                check_value("tie_grant_order", 32'(grant_log[k]), 32'(k % 2));
        end

        // Stalled response
        resp_ready = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h0F0F_0F0F, 5'd8);
        @(posedge clock);
        #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check_value("stall_valid", {31'd0, resp_valid}, 32'd1);
            check_value("stall_ready", {30'd0, req_ready}, 32'd0);
            check_value("stall_data", resp_data, 32'h0F0F_0F00);
            @(posedge clock);
            #1;
        end
        resp_ready = 1'b1;
        @(posedge clock);
        #1;

        // Reset during EXEC
        applyStimulus(1'b1, 1'b0, 32'h0000_00FF, 5'd1);
        pulse_reset();
        @(negedge clock);
        check_value("exec_rst_busy", {31'd0, busy}, 32'd0);
        check_value("exec_rst_valid", {31'd0, resp_valid}, 32'd0);
        check_value("exec_rst_count", {28'd0, op_count}, 32'd0);
        @(posedge clock);
        #1;
        req_valid = 2'b11;
        @(negedge clock);
        check_value("exec_rst_tie", {30'd0, req_ready}, 32'd1);
        @(posedge clock);
        #1;
        req_valid = 2'b00;
        repeat (4) @(posedge clock);
        #1;

        // Reset during RESP, with resp_ready high in the reset cycle
        applyStimulus(1'b0, 1'b0, 32'h0000_0003, 5'd2);
        @(posedge clock);
        #1;
        pulse_reset();
        @(negedge clock);
        check_value("resp_rst_busy", {31'd0, busy}, 32'd0);
        check_value("resp_rst_valid", {31'd0, resp_valid}, 32'd0);
        check_value("resp_rst_count", {28'd0, op_count}, 32'd0);
        @(posedge clock);
        #1;
        req_valid = 2'b11;
        @(negedge clock);
        check_value("resp_rst_tie", {30'd0, req_ready}, 32'd1);
        @(posedge clock);
        #1;
        req_valid = 2'b00;
        repeat (4) @(posedge clock);
        #1;

        // Counter wrap: bring op_count to all-ones, then one more
        guard = 0;
        while (m_count != 15 && guard < 20) begin
            applyStimulus(guard[0], 1'b0, 32'(guard + 1), 5'(guard));
            checkOutput(guard[0], model_shift(1'b0, 32'(guard + 1), 5'(guard)));
            guard++;
        end
        @(negedge clock);
        check_value("count_all_ones", {28'd0, op_count}, 32'd15);
        @(posedge clock);
        #1;
        applyStimulus(1'b0, 1'b1, 32'h8000_0001, 5'd31);
        checkOutput(1'b0, 32'hFFFF_FFFF);
        @(negedge clock);
        check_value("count_wrap", {28'd0, op_count}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule
